// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the IF/MEM single-port RAM arbiter: state and owner
// encodings plus the default RAM latency and starvation limit.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    localparam int MEM_LAT_DEFAULT      = 2;
    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int CNT_W                = 3;
    localparam int STARVE_W             = 4;

endpackage

// File: rtl/mem_port_arb.sv
// Arbiter sharing one single-port RAM between instruction fetch and data
// access; one transaction in flight, MEM priority with IF anti-starvation.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int MEM_LAT      = MEM_LAT_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        flush_if,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        stall_if,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        stall_mem,
    output logic        ram_en,
    output logic        ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        err
);

    localparam logic [CNT_W-1:0]    LAT_INIT   = CNT_W'(MEM_LAT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  err_q, err_d;
    logic                  flushed_q, flushed_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [29:0]           ram_addr_q, ram_addr_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;
    logic [31:0]           if_rdata_q, if_rdata_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;
    logic                  if_done_q, if_done_d;
    logic                  mem_done_q, mem_done_d;
    logic                  mem_req;
    logic                  if_wins;

    assign mem_req = mem_rd | mem_wr;
    assign if_wins = if_req & ((starve_q == STARVE_MAX) | ~mem_req);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        err_d       = err_q;
        flushed_d   = flushed_q;
        ram_en_d    = 1'b0;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        if (!if_req) starve_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req || if_req) begin
                    state_d   = ST_WAIT;
                    cnt_d     = LAT_INIT;
                    ram_en_d  = 1'b1;
                    flushed_d = 1'b0;
                    if (if_wins) begin
                        owner_d     = OWN_IF;
                        ram_we_d    = 1'b0;
                        ram_addr_d  = if_addr[31:2];
                        ram_wdata_d = '0;
                        starve_d    = '0;
                    end else begin
                        owner_d     = OWN_MEM;
                        ram_we_d    = mem_wr;
                        ram_addr_d  = mem_addr[31:2];
                        ram_wdata_d = mem_wr ? mem_wdata : 32'd0;
                        if (if_req && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
                        if ((mem_rd && mem_wr) || mem_addr[1:0] != 2'b00) err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                flushed_d = flushed_q | flush_if;
                // Count runs MEM_LAT..0 so the capture lands on the cycle ram_rdata is valid.
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = ram_rdata;
                        if_done_d  = ~(flushed_q | flush_if);
                    end else begin
                        mem_rdata_d = ram_we_q ? 32'd0 : ram_rdata;
                        mem_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            starve_q    <= '0;
            err_q       <= 1'b0;
            flushed_q   <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            err_q       <= err_d;
            flushed_q   <= flushed_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // A flush arriving in the response cycle itself still has to cancel the pulse.
    assign if_done   = if_done_q & ~flush_if;
    assign mem_done  = mem_done_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = mem_req & ~mem_done;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: transaction-level timeline model checked
// every cycle, plus literal expectations scheduled at absolute cycles.
module tb_mem_port_arb;

    localparam int L  = 2;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, flush_if, mem_rd, mem_wr;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
    logic        if_done, stall_if, mem_done, stall_mem, ram_en, ram_we, err;
    logic [29:0] ram_addr;

    always #5 clk = ~clk;

    mem_port_arb #(.MEM_LAT(L), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
        .if_rdata(if_rdata), .if_done(if_done), .stall_if(stall_if),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_mem(stall_mem),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .err(err)
    );

    function automatic logic [31:0] init_word(input logic [9:0] idx);
        if (idx == 10'h010) return 32'h2402_0005;
        return 32'hA500_0000 | {22'd0, idx};
    endfunction

    // RAM responder: data appears L cycles after the strobe
    logic [31:0] ram_mem [1024];
    bit          ram_wr  [1024];
    logic [31:0] pipe    [L];
    always @(posedge clk) begin
        if (ram_en) begin
            pipe[0] <= ram_wr[ram_addr[9:0]] ? ram_mem[ram_addr[9:0]] : init_word(ram_addr[9:0]);
            if (ram_we) begin
                ram_mem[ram_addr[9:0]] <= ram_wdata;
                ram_wr[ram_addr[9:0]]  <= 1'b1;
            end
        end else begin
            pipe[0] <= 32'h0BAD_0BAD;
        end
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata = pipe[L-1];

    // Timeline model: grant at cycle g -> strobe g+1, done g+2+L, next grant g+3+L
    int          cyc_m = 0;
    bit          m_busy = 0, m_if_owner = 0, m_we = 0, m_flushed = 0, m_err = 0;
    int          m_g = 0, m_starve = 0;
    logic [31:0] m_data = 0, m_if_rdata = 0, m_mem_rdata = 0, m_ram_wdata = 0;
    logic [29:0] m_ram_addr = 0;
    logic [31:0] shadow [1024];
    bit          shadow_wr [1024];

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_busy = 0; m_starve = 0; m_err = 0; m_we = 0;
                m_if_rdata = 0; m_mem_rdata = 0; m_ram_addr = 0; m_ram_wdata = 0;
            end else begin
                automatic int  t = cyc_m;
                automatic bit  can = !m_busy;
                automatic bit  g_if = 0, g_mem = 0;
                automatic logic [31:0] a;
                if (m_busy && m_if_owner && t >= m_g + 1 && t <= m_g + 1 + L && flush_if) m_flushed = 1;
                if (m_busy && t == m_g + 1 + L) begin
                    if (m_if_owner) m_if_rdata = m_data;
                    else            m_mem_rdata = m_we ? 32'd0 : m_data;
                end
                if (m_busy && t == m_g + 2 + L) m_busy = 0;
                if (can) begin
                    if (if_req && (m_starve >= SL || !(mem_rd || mem_wr))) g_if = 1;
                    else if (mem_rd || mem_wr) g_mem = 1;
                end
                if (g_if || g_mem) begin
                    a = g_if ? if_addr : mem_addr;
                    m_busy = 1; m_g = t; m_if_owner = g_if; m_flushed = 0;
                    m_we = g_mem && mem_wr;
                    m_ram_addr = a[31:2];
                    m_ram_wdata = m_we ? mem_wdata : 32'd0;
                    m_data = shadow_wr[a[11:2]] ? shadow[a[11:2]] : init_word(a[11:2]);
                    if (m_we) begin shadow[a[11:2]] = mem_wdata; shadow_wr[a[11:2]] = 1; end
                    if (g_mem && ((mem_rd && mem_wr) || a[1:0] != 2'b00)) m_err = 1;
                end
                if (!if_req || g_if) m_starve = 0;
                else if (g_mem && m_starve < SL) m_starve = m_starve + 1;
            end
            cyc_m = cyc_m + 1;
        end
    end

    // Literal expectations scheduled by the stimulus
    int          lit_n = 0;
    int          lit_cyc [64];
    int          lit_sel [64];
    logic [31:0] lit_exp [64];
    string       lit_nm  [64];

    task automatic expect_at(input int cy, input int sel, input logic [31:0] v, input string nm);
        lit_cyc[lit_n] = cy; lit_sel[lit_n] = sel; lit_exp[lit_n] = v; lit_nm[lit_n] = nm;
        lit_n = lit_n + 1;
    endtask

    function automatic logic [31:0] sig(input int sel);
        case (sel)
            0: return {31'd0, ram_en};
            1: return {31'd0, ram_we};
            2: return {2'd0, ram_addr};
            3: return ram_wdata;
            4: return {31'd0, if_done};
            5: return if_rdata;
            6: return {31'd0, mem_done};
            7: return mem_rdata;
            default: return {31'd0, err};
        endcase
    endfunction

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc_m, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_ram_en", {31'd0, ram_en}, 0);
                chk("rst_ram_we", {31'd0, ram_we}, 0);
                chk("rst_ram_addr", {2'd0, ram_addr}, 0);
                chk("rst_ram_wdata", ram_wdata, 0);
                chk("rst_if_done", {31'd0, if_done}, 0);
                chk("rst_mem_done", {31'd0, mem_done}, 0);
                chk("rst_if_rdata", if_rdata, 0);
                chk("rst_mem_rdata", mem_rdata, 0);
                chk("rst_err", {31'd0, err}, 0);
                chk("rst_stall_if", {31'd0, stall_if}, {31'd0, if_req});
                chk("rst_stall_mem", {31'd0, stall_mem}, {31'd0, mem_rd | mem_wr});
            end else begin
                automatic bit dc = m_busy && cyc_m == m_g + 2 + L;
                automatic bit e_ifd = dc && m_if_owner && !(m_flushed || flush_if);
                automatic bit e_md = dc && !m_if_owner;
                chk("ram_en", {31'd0, ram_en}, {31'd0, m_busy && cyc_m == m_g + 1});
                chk("ram_we", {31'd0, ram_we}, {31'd0, m_we});
                chk("ram_addr", {2'd0, ram_addr}, {2'd0, m_ram_addr});
                chk("ram_wdata", ram_wdata, m_ram_wdata);
                chk("if_done", {31'd0, if_done}, {31'd0, e_ifd});
                chk("mem_done", {31'd0, mem_done}, {31'd0, e_md});
                chk("if_rdata", if_rdata, m_if_rdata);
                chk("mem_rdata", mem_rdata, m_mem_rdata);
                chk("err", {31'd0, err}, {31'd0, m_err});
                chk("stall_if", {31'd0, stall_if}, {31'd0, if_req & ~e_ifd});
                chk("stall_mem", {31'd0, stall_mem}, {31'd0, (mem_rd | mem_wr) & ~e_md});
            end
            for (int i = 0; i < lit_n; i++)
                if (lit_cyc[i] == cyc_m) chk(lit_nm[i], sig(lit_sel[i]), lit_exp[i]);
        end
    end

    task automatic next(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        reset_n = 0; if_req = 0; flush_if = 0; mem_rd = 0; mem_wr = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        next(3);
        reset_n = 1;
        next(2);

        // Single IF read of 0x40
        t = cyc_m;
        if_req = 1; if_addr = 32'h0000_0040;
        expect_at(t + 1, 0, 1, "if_rd_ram_en");
        expect_at(t + 1, 2, 32'h10, "if_rd_ram_addr");
        expect_at(t + 2, 0, 0, "if_rd_ram_en_once");
        expect_at(t + 4, 4, 1, "if_rd_done");
        expect_at(t + 4, 5, 32'h2402_0005, "if_rd_rdata");
        next(5);
        if_req = 0;
        next(2);

        // IF and MEM write together: MEM first, IF next
        t = cyc_m;
        if_req = 1; if_addr = 32'h100;
        mem_wr = 1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
        expect_at(t + 1, 1, 1, "both_ram_we");
        expect_at(t + 1, 2, 32'h40, "both_ram_addr");
        expect_at(t + 1, 3, 32'hDEAD_BEEF, "both_ram_wdata");
        expect_at(t + 4, 6, 1, "both_mem_done");
        expect_at(t + 4, 7, 0, "both_wr_rdata");
        expect_at(t + 4, 4, 0, "both_if_not_yet");
        expect_at(t + 6, 0, 1, "both_if_ram_en");
        expect_at(t + 6, 1, 0, "both_if_ram_we");
        expect_at(t + 9, 4, 1, "both_if_done");
        expect_at(t + 9, 5, 32'hDEAD_BEEF, "both_if_rdata");
        next(5);
        mem_wr = 0;
        next(5);
        if_req = 0;
        next(2);

        // Flush in the cycle after an IF grant
        t = cyc_m;
        if_req = 1; if_addr = 32'h40;
        expect_at(t + 1, 0, 1, "flush_ram_en");
        expect_at(t + 4, 4, 0, "flush_no_done");
        next(1);
        flush_if = 1;
        next(1);
        flush_if = 0;
        next(2);
        if_req = 0;
        next(2);
        if_req = 1; if_addr = 32'h100;
        expect_at(t + 7, 0, 1, "post_flush_ram_en");
        expect_at(t + 10, 4, 1, "post_flush_done");
        expect_at(t + 10, 5, 32'hDEAD_BEEF, "post_flush_rdata");
        next(5);
        if_req = 0;
        next(2);

        // Read+write together, misaligned: write word 0x40, sticky err
        t = cyc_m;
        mem_rd = 1; mem_wr = 1; mem_addr = 32'h102; mem_wdata = 32'h1234_5678;
        expect_at(t, 8, 0, "err_before");
        expect_at(t + 1, 1, 1, "rw_ram_we");
        expect_at(t + 1, 2, 32'h40, "rw_ram_addr");
        expect_at(t + 1, 3, 32'h1234_5678, "rw_ram_wdata");
        expect_at(t + 1, 8, 1, "rw_err");
        expect_at(t + 4, 6, 1, "rw_mem_done");
        expect_at(t + 4, 7, 0, "rw_mem_rdata");
        expect_at(t + 20, 8, 1, "err_sticky");
        next(5);
        mem_rd = 0; mem_wr = 0;
        next(2);

        // Starvation: four MEM grants then IF
        t = cyc_m;
        mem_rd = 1; mem_addr = 32'h200;
        if_req = 1; if_addr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            expect_at(t + 1 + 5 * k, 2, 32'h80, "starve_mem_addr");
            expect_at(t + 4 + 5 * k, 6, 1, "starve_mem_done");
        end
        expect_at(t + 19, 4, 0, "starve_if_waiting");
        expect_at(t + 21, 0, 1, "starve_if_ram_en");
        expect_at(t + 21, 2, 32'h20, "starve_if_addr");
        expect_at(t + 24, 4, 1, "starve_if_done");
        expect_at(t + 24, 5, 32'hA500_0020, "starve_if_rdata");
        next(25);
        mem_rd = 0; if_req = 0;
        next(2);

        // Reset during WAIT, then a normal request
        t = cyc_m;
        if_req = 1; if_addr = 32'h40;
        expect_at(t + 1, 0, 1, "rstw_ram_en");
        next(2);
        reset_n = 0; if_req = 0;
        expect_at(t + 2, 8, 0, "rstw_err_clr");
        expect_at(t + 2, 2, 0, "rstw_ram_addr");
        next(2);
        reset_n = 1;
        expect_at(t + 4, 4, 0, "rstw_no_done");
        next(2);
        mem_rd = 1; mem_addr = 32'h40;
        expect_at(t + 7, 0, 1, "rstw_new_ram_en");
        expect_at(t + 7, 2, 32'h10, "rstw_new_addr");
        expect_at(t + 10, 6, 1, "rstw_new_done");
        expect_at(t + 10, 7, 32'h2402_0005, "rstw_new_rdata");
        next(5);
        mem_rd = 0;
        next(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
